// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU codes,
// sequencer states and instruction-register field positions.
package cpu_defs_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;
  localparam int C_MSB   = 18;
  localparam int C_LSB   = 0;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU code set differs from the opcode numbering for the shift/rotate group
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_SHR  = 5'b00111;
  localparam logic [4:0] ALU_SHRA = 5'b01000;
  localparam logic [4:0] ALU_SHL  = 5'b01001;
  localparam logic [4:0] ALU_ROR  = 5'b01010;
  localparam logic [4:0] ALU_ROL  = 5'b01011;
  localparam logic [4:0] ALU_MUL  = 5'b01111;
  localparam logic [4:0] ALU_DIV  = 5'b10000;
  localparam logic [4:0] ALU_NEG  = 5'b10001;
  localparam logic [4:0] ALU_NOT  = 5'b10010;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FETCH2,
    S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef struct packed {
    logic alu_reg;
    logic alu_imm;
    logic mul_div;
    logic unary;
    logic ld;
    logic ldi;
    logic st;
    logic br;
    logic jr;
    logic jal;
    logic in_port;
    logic out_port;
    logic mfhi;
    logic mflo;
    logic halt;
  } instr_class_t;

  function automatic state_t next_exec_state(input state_t s);
    case (s)
      S_T3:    return S_T4;
      S_T4:    return S_T5;
      S_T5:    return S_T6;
      S_T6:    return S_T7;
      default: return S_FETCH0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Opcode to instruction-class one-hot decode, the final execute step of each
// class, and the ALU code issued during the execute sequence.
module instr_decoder
  import cpu_defs_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t cls,
  output logic         is_exec,
  output state_t       last_state,
  output logic [4:0]   exec_alu_op
);

  always_comb begin
    cls         = '0;
    exec_alu_op = ALU_NONE;
    case (opcode)
      OP_ADD:  begin cls.alu_reg = 1'b1; exec_alu_op = ALU_ADD;  end
      OP_SUB:  begin cls.alu_reg = 1'b1; exec_alu_op = ALU_SUB;  end
      OP_AND:  begin cls.alu_reg = 1'b1; exec_alu_op = ALU_AND;  end
      OP_OR:   begin cls.alu_reg = 1'b1; exec_alu_op = ALU_OR;   end
      OP_ROR:  begin cls.alu_reg = 1'b1; exec_alu_op = ALU_ROR;  end
      OP_ROL:  begin cls.alu_reg = 1'b1; exec_alu_op = ALU_ROL;  end
      OP_SHR:  begin cls.alu_reg = 1'b1; exec_alu_op = ALU_SHR;  end
      OP_SHRA: begin cls.alu_reg = 1'b1; exec_alu_op = ALU_SHRA; end
      OP_SHL:  begin cls.alu_reg = 1'b1; exec_alu_op = ALU_SHL;  end
      OP_ADDI: begin cls.alu_imm = 1'b1; exec_alu_op = ALU_ADD;  end
      OP_ANDI: begin cls.alu_imm = 1'b1; exec_alu_op = ALU_AND;  end
      OP_ORI:  begin cls.alu_imm = 1'b1; exec_alu_op = ALU_OR;   end
      OP_MUL:  begin cls.mul_div = 1'b1; exec_alu_op = ALU_MUL;  end
      OP_DIV:  begin cls.mul_div = 1'b1; exec_alu_op = ALU_DIV;  end
      OP_NEG:  begin cls.unary   = 1'b1; exec_alu_op = ALU_NEG;  end
      OP_NOT:  begin cls.unary   = 1'b1; exec_alu_op = ALU_NOT;  end
      OP_LD:   cls.ld       = 1'b1;
      OP_LDI:  cls.ldi      = 1'b1;
      OP_ST:   cls.st       = 1'b1;
      OP_BR:   cls.br       = 1'b1;
      OP_JR:   cls.jr       = 1'b1;
      OP_JAL:  cls.jal      = 1'b1;
      OP_IN:   cls.in_port  = 1'b1;
      OP_OUT:  cls.out_port = 1'b1;
      OP_MFHI: cls.mfhi     = 1'b1;
      OP_MFLO: cls.mflo     = 1'b1;
      OP_HALT: cls.halt     = 1'b1;
      default: cls = '0;
    endcase
  end

  // nop and undefined opcodes leave every class bit low and skip execute
  assign is_exec = (cls != '0) && !cls.halt;

  always_comb begin
    last_state = S_FETCH0;
    if (cls.jr || cls.in_port || cls.out_port || cls.mfhi || cls.mflo)
      last_state = S_T3;
    else if (cls.unary || cls.jal)
      last_state = S_T4;
    else if (cls.alu_reg || cls.alu_imm || cls.ldi)
      last_state = S_T5;
    else if (cls.mul_div || cls.br)
      last_state = S_T6;
    else if (cls.ld || cls.st)
      last_state = S_T7;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: steps fetch/decode/execute and decodes
// every datapath strobe and the ALU opcode from the current state and IR.
module control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic [4:0]  alu_op,
  output logic        pc_out, mdr_out, zhigh_out, zlow_out,
  output logic        hi_out, lo_out, c_out, inport_out,
  output logic        pc_in, ir_in, mar_in, mdr_in, y_in,
  output logic        z_in, hi_in, lo_in, con_in, outport_in,
  output logic        gra, grb, grc, r_in, r_out, ba_out, r15_sel,
  output logic        inc_pc, mem_read, mem_write,
  output logic        run
);

  localparam int CNT_W = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD) : 1;

  state_t             state, state_next;
  logic [CNT_W-1:0]   hold_cnt;
  logic               hold_done;
  instr_class_t       cls;
  logic               is_exec;
  state_t             last_state;
  logic [4:0]         exec_alu_op;

  // Only the opcode steers sequencing; operand fields go straight to the datapath
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir[RA_MSB:C_LSB];

  instr_decoder u_decoder (
    .opcode      (ir[OPC_MSB:OPC_LSB]),
    .cls         (cls),
    .is_exec     (is_exec),
    .last_state  (last_state),
    .exec_alu_op (exec_alu_op)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= S_RESET;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)              hold_cnt <= '0;
    else if (state == S_RESET) hold_cnt <= hold_cnt + CNT_W'(1);
  end

  assign hold_done = (hold_cnt == CNT_W'(RESET_PC_HOLD - 1));

  always_comb begin
    state_next = state;
    case (state)
      S_RESET:  if (hold_done) state_next = S_FETCH0;
      S_FETCH0: state_next = stop ? S_HALT : S_FETCH1;
      S_FETCH1: state_next = S_FETCH2;
      S_FETCH2: begin
        if (cls.halt)      state_next = S_HALT;
        else if (!is_exec) state_next = S_FETCH0;
        else               state_next = S_T3;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7:
        state_next = (state == last_state) ? S_FETCH0 : next_exec_state(state);
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_RESET;
    endcase
  end

  always_comb begin
    alu_op = ALU_NONE;
    pc_out = 1'b0; mdr_out = 1'b0; zhigh_out = 1'b0; zlow_out = 1'b0;
    hi_out = 1'b0; lo_out = 1'b0; c_out = 1'b0; inport_out = 1'b0;
    pc_in = 1'b0; ir_in = 1'b0; mar_in = 1'b0; mdr_in = 1'b0; y_in = 1'b0;
    z_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0; con_in = 1'b0; outport_in = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0;
    ba_out = 1'b0; r15_sel = 1'b0;
    inc_pc = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    run = 1'b0;
    case (state)
      S_FETCH0: begin
        run = 1'b1; pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1;
        z_in = 1'b1; alu_op = ALU_ADD;
      end
      S_FETCH1: begin
        run = 1'b1; zlow_out = 1'b1; pc_in = 1'b1; mem_read = 1'b1; mdr_in = 1'b1;
      end
      S_FETCH2: begin
        run = 1'b1; mdr_out = 1'b1; ir_in = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        if (cls.alu_reg || cls.alu_imm) begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
        else if (cls.mul_div) begin gra = 1'b1; r_out = 1'b1; y_in = 1'b1; end
        else if (cls.unary) begin
          grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = exec_alu_op;
        end
        else if (cls.ld || cls.ldi || cls.st) begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
        else if (cls.br) begin gra = 1'b1; r_out = 1'b1; con_in = 1'b1; end
        else if (cls.jr) begin gra = 1'b1; r_out = 1'b1; pc_in = 1'b1; end
        else if (cls.jal) begin pc_out = 1'b1; r15_sel = 1'b1; r_in = 1'b1; end
        else if (cls.in_port) begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else if (cls.out_port) begin gra = 1'b1; r_out = 1'b1; outport_in = 1'b1; end
        else if (cls.mfhi) begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else if (cls.mflo) begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
      end
      S_T4: begin
        run = 1'b1;
        if (cls.alu_reg) begin
          grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = exec_alu_op;
        end
        else if (cls.alu_imm) begin c_out = 1'b1; z_in = 1'b1; alu_op = exec_alu_op; end
        else if (cls.mul_div) begin
          grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = exec_alu_op;
        end
        else if (cls.unary) begin zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else if (cls.ld || cls.ldi || cls.st) begin c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
        else if (cls.br) begin pc_out = 1'b1; y_in = 1'b1; end
        else if (cls.jal) begin gra = 1'b1; r_out = 1'b1; pc_in = 1'b1; end
      end
      S_T5: begin
        run = 1'b1;
        if (cls.alu_reg || cls.alu_imm || cls.ldi) begin zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else if (cls.mul_div) begin zlow_out = 1'b1; lo_in = 1'b1; end
        else if (cls.ld || cls.st) begin zlow_out = 1'b1; mar_in = 1'b1; end
        else if (cls.br) begin c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
      end
      S_T6: begin
        run = 1'b1;
        if (cls.mul_div) begin zhigh_out = 1'b1; hi_in = 1'b1; end
        else if (cls.ld) begin mem_read = 1'b1; mdr_in = 1'b1; end
        else if (cls.st) begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
        else if (cls.br) begin zlow_out = 1'b1; pc_in = con_ff; end
      end
      S_T7: begin
        run = 1'b1;
        if (cls.ld) begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else if (cls.st) mem_write = 1'b1;
      end
      default: run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a per-opcode step-table model queues
// the expected strobe vector of every cycle, and a monitor compares each cycle.
module tb_control_sequencer;

  localparam int HOLD = 1;

  typedef struct packed {
    logic [4:0] alu_op;
    logic pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out, inport_out;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, con_in, outport_in;
    logic gra, grb, grc, r_in, r_out, ba_out, r15_sel;
    logic inc_pc, mem_read, mem_write, run;
  } outs_t;

  logic        clock, clear_n, con_ff, stop;
  logic [31:0] ir;
  logic [4:0]  alu_op;
  logic pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out, inport_out;
  logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, con_in, outport_in;
  logic gra, grb, grc, r_in, r_out, ba_out, r15_sel;
  logic inc_pc, mem_read, mem_write, run;

  outs_t act;
  assign act = {alu_op, pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out,
                inport_out, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in,
                con_in, outport_in, gra, grb, grc, r_in, r_out, ba_out, r15_sel,
                inc_pc, mem_read, mem_write, run};

  control_sequencer #(.RESET_PC_HOLD(HOLD)) dut (
    .clock(clock), .clear_n(clear_n), .ir(ir), .con_ff(con_ff), .stop(stop),
    .alu_op(alu_op), .pc_out(pc_out), .mdr_out(mdr_out), .zhigh_out(zhigh_out),
    .zlow_out(zlow_out), .hi_out(hi_out), .lo_out(lo_out), .c_out(c_out),
    .inport_out(inport_out), .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .con_in(con_in), .outport_in(outport_in), .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .r15_sel(r15_sel),
    .inc_pc(inc_pc), .mem_read(mem_read), .mem_write(mem_write), .run(run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    n_checks;
  int    n_fails;
  bit    mon_en;
  outs_t exp_q[$];
  string tag_q[$];

  // One expected vector is consumed per clock cycle while monitoring is enabled
  always @(negedge clock) begin
    if (mon_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("[TB] FAIL scoreboard_underflow: got %h, required a queued expectation", act);
      end else begin
        outs_t e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (act !== e) begin
          n_fails++;
          $display("[TB] FAIL %s: got %h required %h", t, act, e);
        end
      end
    end
  end

  task automatic check_output(input string name, input outs_t got, input outs_t want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic emit(input outs_t v, input string t);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  function automatic outs_t busy();
    outs_t v;
    v = '0;
    v.run = 1'b1;
    return v;
  endfunction

  function automatic logic [4:0] alu_for(input logic [4:0] op);
    case (op)
      5'd3: return 5'd3;   5'd4: return 5'd4;   5'd5: return 5'd5;
      5'd6: return 5'd6;   5'd7: return 5'd10;  5'd8: return 5'd11;
      5'd9: return 5'd7;   5'd10: return 5'd8;  5'd11: return 5'd9;
      5'd12: return 5'd3;  5'd13: return 5'd5;  5'd14: return 5'd6;
      5'd15: return 5'd15; 5'd16: return 5'd16; 5'd17: return 5'd17;
      5'd18: return 5'd18;
      default: return 5'd0;
    endcase
  endfunction

  // Queues the cycle-by-cycle strobes for one instruction starting in FETCH0
  task automatic model_instr(input logic [31:0] iw, input logic con, input logic stp,
                             output int ncyc, output bit halts);
    outs_t v;
    logic [4:0] op;
    string nm;
    op = iw[31:27];
    nm = $sformatf("op%0d", op);
    halts = 1'b0;
    v = busy(); v.pc_out = 1; v.mar_in = 1; v.inc_pc = 1; v.z_in = 1; v.alu_op = 5'd3;
    emit(v, {nm, "_fetch0"});
    ncyc = 1;
    if (stp) begin halts = 1'b1; return; end
    v = busy(); v.zlow_out = 1; v.pc_in = 1; v.mem_read = 1; v.mdr_in = 1; emit(v, {nm, "_fetch1"});
    v = busy(); v.mdr_out = 1; v.ir_in = 1; emit(v, {nm, "_fetch2"});
    ncyc = 3;
    if (op == 5'd27) begin halts = 1'b1; return; end
    if (op inside {[5'd3:5'd14]}) begin
      v = busy(); v.grb = 1; v.r_out = 1; v.y_in = 1; emit(v, {nm, "_t3"});
      v = busy(); v.z_in = 1; v.alu_op = alu_for(op);
      if (op <= 5'd11) begin v.grc = 1; v.r_out = 1; end else v.c_out = 1;
      emit(v, {nm, "_t4"});
      v = busy(); v.zlow_out = 1; v.gra = 1; v.r_in = 1; emit(v, {nm, "_t5"});
      ncyc += 3;
    end else if (op == 5'd15 || op == 5'd16) begin
      v = busy(); v.gra = 1; v.r_out = 1; v.y_in = 1; emit(v, {nm, "_t3"});
      v = busy(); v.grb = 1; v.r_out = 1; v.z_in = 1; v.alu_op = alu_for(op); emit(v, {nm, "_t4"});
      v = busy(); v.zlow_out = 1; v.lo_in = 1; emit(v, {nm, "_t5"});
      v = busy(); v.zhigh_out = 1; v.hi_in = 1; emit(v, {nm, "_t6"});
      ncyc += 4;
    end else if (op == 5'd17 || op == 5'd18) begin
      v = busy(); v.grb = 1; v.r_out = 1; v.z_in = 1; v.alu_op = alu_for(op); emit(v, {nm, "_t3"});
      v = busy(); v.zlow_out = 1; v.gra = 1; v.r_in = 1; emit(v, {nm, "_t4"});
      ncyc += 2;
    end else if (op <= 5'd2) begin
      v = busy(); v.grb = 1; v.ba_out = 1; v.y_in = 1; emit(v, {nm, "_t3"});
      v = busy(); v.c_out = 1; v.z_in = 1; v.alu_op = 5'd3; emit(v, {nm, "_t4"});
      if (op == 5'd1) begin
        v = busy(); v.zlow_out = 1; v.gra = 1; v.r_in = 1; emit(v, {nm, "_t5"});
        ncyc += 3;
      end else begin
        v = busy(); v.zlow_out = 1; v.mar_in = 1; emit(v, {nm, "_t5"});
        v = busy();
        if (op == 5'd0) begin v.mem_read = 1; v.mdr_in = 1; end
        else begin v.gra = 1; v.r_out = 1; v.mdr_in = 1; end
        emit(v, {nm, "_t6"});
        v = busy();
        if (op == 5'd0) begin v.mdr_out = 1; v.gra = 1; v.r_in = 1; end
        else v.mem_write = 1;
        emit(v, {nm, "_t7"});
        ncyc += 5;
      end
    end else if (op == 5'd19) begin
      v = busy(); v.gra = 1; v.r_out = 1; v.con_in = 1; emit(v, {nm, "_t3"});
      v = busy(); v.pc_out = 1; v.y_in = 1; emit(v, {nm, "_t4"});
      v = busy(); v.c_out = 1; v.z_in = 1; v.alu_op = 5'd3; emit(v, {nm, "_t5"});
      v = busy(); v.zlow_out = 1; v.pc_in = con; emit(v, {nm, "_t6"});
      ncyc += 4;
    end else if (op == 5'd21) begin
      v = busy(); v.pc_out = 1; v.r15_sel = 1; v.r_in = 1; emit(v, {nm, "_t3"});
      v = busy(); v.gra = 1; v.r_out = 1; v.pc_in = 1; emit(v, {nm, "_t4"});
      ncyc += 2;
    end else if (op inside {5'd20, 5'd22, 5'd23, 5'd24, 5'd25}) begin
      v = busy(); v.gra = 1;
      case (op)
        5'd20: begin v.r_out = 1; v.pc_in = 1; end
        5'd22: begin v.inport_out = 1; v.r_in = 1; end
        5'd23: begin v.r_out = 1; v.outport_in = 1; end
        5'd24: begin v.hi_out = 1; v.r_in = 1; end
        default: begin v.lo_out = 1; v.r_in = 1; end
      endcase
      emit(v, {nm, "_t3"});
      ncyc += 1;
    end
  endtask

  task automatic hold_halt(input int n);
    repeat (n) emit('0, "halt_idle");
    repeat (n) begin
      @(posedge clock); #1;
      ir = $urandom;
      stop = 1'($urandom_range(0, 1));
    end
    stop = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [31:0] iw, input logic con, input logic stp);
    int n;
    bit h;
    ir = iw; con_ff = con; stop = stp;
    model_instr(iw, con, stp, n, h);
    repeat (n) begin @(posedge clock); #1; stop = 1'b0; end
    if (h) hold_halt(stp ? 20 : 100);
  endtask

  task automatic release_reset();
    @(posedge clock); #1;
    clear_n = 1'b1;
    repeat (HOLD) emit('0, "reset_state");
    mon_en = 1'b1;
    repeat (HOLD) begin @(posedge clock); #1; end
  endtask

  task automatic assert_reset(input string name);
    clear_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check_output(name, act, '0);
    exp_q.delete();
    tag_q.delete();
  endtask

  initial begin
    n_checks = 0; n_fails = 0; mon_en = 1'b0;
    clear_n = 1'b0; ir = '0; con_ff = 1'b0; stop = 1'b0;
    repeat (3) begin @(posedge clock); #1; check_output("reset_outputs", act, '0); end
    release_reset();

    apply_stimulus(32'h18918000, 1'b0, 1'b0);
    apply_stimulus({5'b01111, 27'($urandom)}, 1'b0, 1'b0);
    apply_stimulus({5'b10011, 27'($urandom)}, 1'b0, 1'b0);
    apply_stimulus({5'b10011, 27'($urandom)}, 1'b1, 1'b0);
    apply_stimulus({5'b00000, 27'($urandom)}, 1'b0, 1'b0);
    apply_stimulus({5'b00010, 27'($urandom)}, 1'b1, 1'b0);
    apply_stimulus({5'b11010, 27'($urandom)}, 1'b0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      apply_stimulus({op, 27'($urandom)}, 1'($urandom_range(0, 1)), 1'b0);
    end

    apply_stimulus({5'b00011, 27'($urandom)}, 1'b0, 1'b1);
    assert_reset("reset_from_stop_halt");
    release_reset();

    apply_stimulus(32'hD8000000, 1'b0, 1'b0);
    assert_reset("reset_from_halt");
    release_reset();

    ir = {5'b01111, 27'($urandom)};
    begin
      int n;
      bit h;
      model_instr(ir, 1'b0, 1'b0, n, h);
    end
    repeat (4) begin @(posedge clock); #1; end
    @(negedge clock); #2;
    assert_reset("mid_mul_reset");
    @(posedge clock); #1;
    check_output("reset_after_edge", act, '0);
    release_reset();
    apply_stimulus(32'h18918000, 1'b1, 1'b0);

    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
